// File: rtl/rv_pkg.sv
// Shared branch-unit definitions: comparator opcodes, branch funct3 codes and PC FSM states.
package rv_pkg;

    localparam logic [1:0] CMP_EQ   = 2'b11;
    localparam logic [1:0] CMP_SLT  = 2'b01;
    localparam logic [1:0] CMP_SLTU = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Instruction-side and redirect signals of the PC/branch unit, bundled for one port.
interface pc_branch_unit_if;

    logic        stall;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] cmp_o;
    logic [1:0]  cmp_op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        misalign;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    modport master (
        output stall, branch, jal, jalr, funct3, imm, rs1, cmp_o,
        input  cmp_op, pc, pc_plus4, taken, misalign, br_count, taken_count
    );

    modport slave (
        input  stall, branch, jal, jalr, funct3, imm, rs1, cmp_o,
        output cmp_op, pc, pc_plus4, taken, misalign, br_count, taken_count
    );

endinterface

// File: rtl/branch_cond_decode.sv
// Maps a branch funct3 onto the external comparator opcode plus a result-invert bit.
module branch_cond_decode
    import rv_pkg::*;
(
    input  logic       branch,
    input  logic [2:0] funct3,
    output logic [1:0] cmp_op,
    output logic       invert,
    output logic       valid
);

    // Unused funct3 codes are flagged invalid; the comparator is never handed 00.
    always_comb begin
        cmp_op = CMP_EQ;
        invert = 1'b0;
        valid  = 1'b1;
        case (funct3)
            F3_BEQ:  cmp_op = CMP_EQ;
            F3_BNE:  begin cmp_op = CMP_EQ;   invert = 1'b1; end
            F3_BLT:  cmp_op = CMP_SLT;
            F3_BGE:  begin cmp_op = CMP_SLT;  invert = 1'b1; end
            F3_BLTU: cmp_op = CMP_SLTU;
            F3_BGEU: begin cmp_op = CMP_SLTU; invert = 1'b1; end
            default: valid = 1'b0;
        endcase
        if (!branch) begin
            cmp_op = CMP_EQ;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register with branch/JAL/JALR redirect, misaligned-target trap and optional
// branch statistics (enabled by defining BRANCH_STATS_EN).
module pc_branch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    pc_branch_unit_if.slave bus
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target;
    logic [31:0] jalr_sum;
    logic        mis_q, mis_d;
    logic        invert;
    logic        f3_valid;
    logic        cond;
    logic        redirect;
    logic        running;
    logic        unused_cmp_hi;

    branch_cond_decode u_decode (
        .branch (bus.branch),
        .funct3 (bus.funct3),
        .cmp_op (bus.cmp_op),
        .invert (invert),
        .valid  (f3_valid)
    );

    assign cond          = f3_valid & (bus.cmp_o[0] ^ invert);
    assign unused_cmp_hi = ^bus.cmp_o[31:1];
    assign redirect      = bus.jalr | bus.jal | (bus.branch & cond);
    assign running       = (state_q == ST_RUN);
    assign jalr_sum      = bus.rs1 + bus.imm;

    always_comb begin
        if (bus.jalr) begin
            target = {jalr_sum[31:1], 1'b0};
        end else if (bus.jal | (bus.branch & cond)) begin
            target = pc_q + bus.imm;
        end else begin
            target = pc_q + 32'd4;
        end
    end

    // A misaligned redirect traps without moving the PC; HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (redirect && !is_aligned(target)) begin
                        mis_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + 32'd4;
    assign bus.taken    = running & redirect;
    assign bus.misalign = mis_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_q, tk_q;
    logic        count_en;

    assign count_en = running & ~bus.stall & bus.branch;

    // Saturating counters: a wrap would silently corrupt long profiling runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q <= '0;
            tk_q <= '0;
        end else if (count_en) begin
            if (br_q != 32'hFFFF_FFFF) begin
                br_q <= br_q + 32'd1;
            end
            if (cond && (tk_q != 32'hFFFF_FFFF)) begin
                tk_q <= tk_q + 32'd1;
            end
        end
    end

    assign bus.br_count    = br_q;
    assign bus.taken_count = tk_q;
`else
    assign bus.br_count    = '0;
    assign bus.taken_count = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios followed by random traffic
// against a behavioural model that evaluates branch relations on real operands.
module tb_pc_branch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_branch_unit_if bus ();

    pc_branch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External comparator: compares two operands as the DUT's cmp_op asks, with junk upper bits.
    logic [31:0] opa, opb, junk;
    logic        cmp_bit;

    always_comb begin
        case (bus.cmp_op)
            2'b11:   cmp_bit = (opa == opb);
            2'b01:   cmp_bit = ($signed(opa) < $signed(opb));
            2'b10:   cmp_bit = (opa < opb);
            default: cmp_bit = 1'b0;
        endcase
    end

    assign bus.cmp_o = {junk[31:1], cmp_bit};

    logic [31:0] m_pc, m_br, m_tk;
    logic        m_halt, m_mis;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  last_cmp_op;
    logic        last_taken;

    logic [31:0] pool [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] r_imm, r_rs1, r_a, r_b;
    logic [2:0]  r_f3;
    logic        r_stall, r_br, r_jal, r_jalr;

    // Architectural meaning of each branch mnemonic, straight from the ISA.
    function automatic logic relation(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] expected_cmp_op(input logic br, input logic [2:0] f3);
        if (!br) return 2'b11;
        case (f3)
            3'b100, 3'b101: return 2'b01;
            3'b110, 3'b111: return 2'b10;
            default:        return 2'b11;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic br, input logic jl, input logic jr,
                                 input logic [2:0] f3, input logic [31:0] im, input logic [31:0] r1,
                                 input logic [31:0] a, input logic [31:0] b);
        logic        rel_ok, exp_taken;
        logic [31:0] target;
        @(negedge clk);
        bus.stall  = s;
        bus.branch = br;
        bus.jal    = jl;
        bus.jalr   = jr;
        bus.funct3 = f3;
        bus.imm    = im;
        bus.rs1    = r1;
        opa        = a;
        opb        = b;
        junk       = $urandom;
        #1;
        rel_ok    = br && relation(f3, a, b);
        exp_taken = !m_halt && (jr || jl || rel_ok);
        if (jr)                 target = (r1 + im) & ~32'h1;
        else if (jl || rel_ok)  target = m_pc + im;
        else                    target = m_pc + 32'd4;
        last_cmp_op = bus.cmp_op;
        last_taken  = bus.taken;
        checkOutput("cmp_op",   {30'b0, bus.cmp_op}, {30'b0, expected_cmp_op(br, f3)});
        checkOutput("taken",    {31'b0, bus.taken},  {31'b0, exp_taken});
        checkOutput("pc_plus4", bus.pc_plus4,        m_pc + 32'd4);
        @(posedge clk);
        #1;
        if (!s && !m_halt) begin
            if (exp_taken && (target[1:0] != 2'b00)) begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
            end else begin
                m_pc = target;
            end
`ifdef BRANCH_STATS_EN
            if (br && (m_br != 32'hFFFF_FFFF)) m_br = m_br + 32'd1;
            if (rel_ok && (m_tk != 32'hFFFF_FFFF)) m_tk = m_tk + 32'd1;
`endif
        end
        checkOutput("pc",          bus.pc,                m_pc);
        checkOutput("misalign",    {31'b0, bus.misalign}, {31'b0, m_mis});
        checkOutput("br_count",    bus.br_count,          m_br);
        checkOutput("taken_count", bus.taken_count,       m_tk);
    endtask

    task automatic doReset(input logic s);
        @(negedge clk);
        rst       = 1'b1;
        bus.stall = s;
        bus.jal   = 1'b1;
        bus.imm   = 32'h6;
        #2;
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        m_mis  = 1'b0;
        m_br   = '0;
        m_tk   = '0;
        checkOutput("rst_pc",          bus.pc,                RESET_PC);
        checkOutput("rst_misalign",    {31'b0, bus.misalign}, 32'h0);
        checkOutput("rst_br_count",    bus.br_count,          32'h0);
        checkOutput("rst_taken_count", bus.taken_count,       32'h0);
        @(negedge clk);
        bus.stall = 1'b1;
        bus.jal   = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.stall  = 1'b1;
        bus.branch = 1'b0;
        bus.jal    = 1'b0;
        bus.jalr   = 1'b0;
        bus.funct3 = 3'b000;
        bus.imm    = '0;
        bus.rs1    = '0;
        opa = '0; opb = '0; junk = '0;
        m_pc = RESET_PC; m_halt = 1'b0; m_mis = 1'b0; m_br = '0; m_tk = '0;

        doReset(1'b1);

        // BGEU with 1 < 2 unsigned: not taken, falls through
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 32'h20, 32'h0, 32'h1, 32'h2);
        checkOutput("bgeu_cmp_op", {30'b0, last_cmp_op}, 32'h2);
        checkOutput("bgeu_taken",  {31'b0, last_taken},  32'h0);
        checkOutput("bgeu_pc",     bus.pc,               32'h104);

        doReset(1'b0);
        // BNE with unequal operands: taken to pc+0x20
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h20, 32'h0, 32'h1, 32'h2);
        checkOutput("bne_cmp_op", {30'b0, last_cmp_op}, 32'h3);
        checkOutput("bne_taken",  {31'b0, last_taken},  32'h1);
        checkOutput("bne_pc",     bus.pc,               32'h120);

        // JALR and JAL together: JALR wins with bit 0 cleared
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h1, 32'h203, 32'h0, 32'h0);
        checkOutput("jalr_pc", bus.pc, 32'h204);

        doReset(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h6, 32'h0, 32'h0, 32'h0);
        checkOutput("stall_pc",       bus.pc,                32'h100);
        checkOutput("stall_misalign", {31'b0, bus.misalign}, 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h6, 32'h0, 32'h0, 32'h0);
        checkOutput("trap_pc",       bus.pc,                32'h100);
        checkOutput("trap_misalign", {31'b0, bus.misalign}, 32'h1);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h8, 32'h0, 32'h0, 32'h0);
        checkOutput("halt_taken", {31'b0, last_taken}, 32'h0);
        checkOutput("halt_pc",    bus.pc,              32'h100);

        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("post_trap_pc", bus.pc, 32'h104);

        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h8, 32'h0, 32'h5, 32'h5);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h8, 32'h0, 32'h5, 32'h6);
        end
`ifdef BRANCH_STATS_EN
        checkOutput("stats_br",    bus.br_count,    32'd5);
        checkOutput("stats_taken", bus.taken_count, 32'd3);
`else
        checkOutput("stats_br",    bus.br_count,    32'd0);
        checkOutput("stats_taken", bus.taken_count, 32'd0);
`endif
        checkOutput("stats_pc", bus.pc, 32'h120);

        // Wrap-around is legal modulo arithmetic
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FEE0, 32'h0, 32'h0, 32'h0);
        checkOutput("wrap_pc", bus.pc, 32'h0);

        for (int n = 0; n < 400; n++) begin
            r_stall = ($urandom_range(0, 5) == 0);
            r_br    = ($urandom_range(0, 1) == 1);
            r_jal   = ($urandom_range(0, 6) == 0);
            r_jalr  = ($urandom_range(0, 9) == 0);
            r_f3    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r_imm = $urandom;
            else                            r_imm = (32'($urandom_range(0, 64)) - 32'd32) << 2;
            if ($urandom_range(0, 5) == 0) r_rs1 = $urandom;
            else                            r_rs1 = $urandom & 32'hFFFF_FFFC;
            r_a = pool[$urandom_range(0, 3)];
            r_b = pool[$urandom_range(0, 3)];
            applyStimulus(r_stall, r_br, r_jal, r_jalr, r_f3, r_imm, r_rs1, r_a, r_b);
            if (m_halt && ($urandom_range(0, 2) == 0)) begin
                doReset(($urandom_range(0, 1) == 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  input  1  hold PC and all state this cycle.
REQ-005 SHALL have port branch  input  1  current instruction is a conditional branch.
REQ-006 SHALL have port jal  input  1  current instruction is JAL.
REQ-007 SHALL have port jalr  input  1  current instruction is JALR.
REQ-008 SHALL have port funct3  input  3  branch condition field.
REQ-009 SHALL have port imm  input  32  sign-extended immediate.
REQ-010 SHALL have port rs1  input  32  JALR base register value.
REQ-011 SHALL have port cmp_o  input  32  comparator result; only bit 0 is used.
REQ-012 SHALL have port cmp_op  output  2  comparator opcode: 11 = equal, 01 = signed less-than, 10 = unsigned less-than.
REQ-013 SHALL have port pc  output  32  current PC register.
REQ-014 SHALL have port pc_plus4  output  32  pc+4, the link value for JAL/JALR.
REQ-015 SHALL have port taken  output  1  redirect taken this cycle (combinational).
REQ-016 SHALL have port misalign  output  1  sticky misaligned-target trap flag.
REQ-017 SHALL have ports br_count and taken_count  output  32 each  branch statistics.

Function
REQ-018 SHALL decode funct3 to cmp_op and an invert bit: 000 -> 11/0, 001 -> 11/1, 100 -> 01/0, 101 -> 01/1, 110 -> 10/0, 111 -> 10/1.
REQ-019 SHALL drive cmp_op = 11 whenever branch = 0 or funct3 is 010/011, so the comparator never receives 00.
REQ-020 SHALL compute cond = cmp_o[0] XOR invert; cond SHALL be forced to 0 for funct3 010/011.
REQ-021 SHALL select the target with priority jalr > jal > branch: jalr -> (rs1+imm) with bit 0 cleared; jal, or branch with cond = 1 -> pc+imm; otherwise pc+4.
REQ-022 SHALL assert taken = jalr | jal | (branch & cond) while in RUN, and SHALL hold taken at 0 in HALT.
REQ-023 SHALL use 32-bit modulo arithmetic; wrap-around (e.g. pc 32'hFFFF_FFFC + 4 = 0) SHALL NOT be an error.
REQ-024 SHALL implement an FSM with states RUN and HALT: in RUN with stall = 0, pc <= target each cycle.
REQ-025 SHALL treat a taken target with target[1:0] != 00 as misaligned: pc holds, misalign <= 1, and the FSM moves to HALT on that edge.
REQ-026 SHALL, in HALT, hold pc and misalign, ignore all inputs, and leave HALT only on reset.
REQ-027 SHALL, when stall = 1, update nothing (pc, FSM, counters) and SHALL NOT raise misalign, even for a misaligned target; stall takes priority.
REQ-028 SHALL compute pc_plus4 combinationally from pc at all times, including HALT.

Reset
REQ-029 SHALL, on reset, set pc = RESET_PC, FSM = RUN, misalign = 0, br_count = 0, taken_count = 0, asynchronously and regardless of stall.
REQ-030 SHALL, when reset is asserted mid-HALT, clear the trap; the first edge after deassertion SHALL evaluate normally from RESET_PC.

Configuration
REQ-031 SHALL, with BRANCH_STATS_EN defined, increment br_count on each RUN, non-stalled cycle with branch = 1, and taken_count when additionally cond = 1; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 SHALL, without BRANCH_STATS_EN, keep both ports present, tie them to 0, and instantiate no counter flops.

Structure
REQ-033 SHALL place the cmp_op encodings, the funct3 branch constants and the RUN/HALT state enum in shared package rv_pkg.
REQ-034 SHALL put the funct3 -> {cmp_op, invert} decode in combinational sub-module branch_cond_decode; the comparator itself stays external, driven by cmp_op and read through cmp_o.

Verification
REQ-035 SHALL verify: reset with RESET_PC = 32'h100 -> pc = 32'h100, misalign = 0, counters = 0.
REQ-036 SHALL verify: pc = 32'h100, branch = 1, funct3 = 001, cmp_o = 0, imm = 32'h20 -> cmp_op = 11, taken = 1, next pc = 32'h120.
REQ-037 SHALL verify: pc = 32'h100, funct3 = 111, cmp_o = 1 -> cmp_op = 10, taken = 0, next pc = 32'h104.
REQ-038 SHALL verify: jalr = 1 and jal = 1 together, rs1 = 32'h203, imm = 1 -> next pc = 32'h204 (JALR wins, bit 0 cleared).
REQ-039 SHALL verify: jal = 1, imm = 32'h6 -> pc holds, misalign = 1, FSM = HALT; a further jal is ignored; rst clears the trap and pc returns to RESET_PC.
REQ-040 SHALL verify: stall = 1 with a misaligned jal -> no change; with BRANCH_STATS_EN, 3 taken plus 2 not-taken branches -> br_count = 5, taken_count = 3.
